// File: rtl/psram_arb_pkg.sv
// Shared types for the PSRAM Wishbone arbiter: FSM states, grant encoding
// and the latched slave request fields.
package psram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  localparam logic GNT_M0 = 1'b0;
  localparam logic GNT_M1 = 1'b1;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } req_fields_t;

endpackage

// File: rtl/psram_wb_arbiter_rr_pick2.sv
// Two-way round-robin pick: on contention the master that did not win last time
// goes next.
module rr_pick2
  import psram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       pick
);

  always_comb begin
    valid = |req;
    pick  = GNT_M0;
    if (req == 2'b11)
      pick = ~last_grant;
    else if (req[1])
      pick = GNT_M1;
  end

endmodule

// File: rtl/psram_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the single-port PSRAM controller.
// Holds the granted request stable for the whole transaction.
//
// state   | meaning
// ST_IDLE | slave cyc low, sampling master requests
// ST_BUSY | registered request driven to slave, waiting for ack or timeout
// ST_RESP | ack/err pulse to the grantee, guarantees a cyc-low cycle
module psram_wb_arbiter
  import psram_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  output logic [31:0] m0_dat_o,
  output logic [31:0] m1_dat_o,
  output logic        m0_ack_o,
  output logic        m1_ack_o,
  output logic        m0_err_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic        grant_o,
  output logic        busy_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

  arb_state_t  state;
  req_fields_t fld;
  req_fields_t cand;
  logic [CW-1:0] cnt;
  logic [31:0] rdata;
  logic        last_grant;
  logic        cyc_q;
  logic [1:0]  req;
  logic        pick_vld;
  logic        pick;

  assign req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

  rr_pick2 u_pick (
    .req        (req),
    .last_grant (last_grant),
    .valid      (pick_vld),
    .pick       (pick)
  );

  always_comb begin
    if (pick == GNT_M1)
      cand = '{adr: m1_adr_i, dat: m1_dat_i, sel: m1_sel_i, we: m1_we_i};
    else
      cand = '{adr: m0_adr_i, dat: m0_dat_i, sel: m0_sel_i, we: m0_we_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      fld        <= '0;
      cnt        <= '0;
      rdata      <= '0;
      last_grant <= GNT_M1;
      cyc_q      <= 1'b0;
      busy_o     <= 1'b0;
      m0_ack_o   <= 1'b0;
      m1_ack_o   <= 1'b0;
      m0_err_o   <= 1'b0;
      m1_err_o   <= 1'b0;
    end else begin
      m0_ack_o <= 1'b0;
      m1_ack_o <= 1'b0;
      m0_err_o <= 1'b0;
      m1_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            fld        <= cand;
            last_grant <= pick;
            cnt        <= '0;
            cyc_q      <= 1'b1;
            busy_o     <= 1'b1;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (s_ack_i) begin
            rdata    <= s_dat_i;
            cyc_q    <= 1'b0;
            busy_o   <= 1'b0;
            m0_ack_o <= (last_grant == GNT_M0);
            m1_ack_o <= (last_grant == GNT_M1);
            state    <= ST_RESP;
          end else if ((TIMEOUT != 0) && (cnt == TO_CNT)) begin
            // wedged slave: abort and report err instead of ack
            cyc_q    <= 1'b0;
            busy_o   <= 1'b0;
            m0_err_o <= (last_grant == GNT_M0);
            m1_err_o <= (last_grant == GNT_M1);
            state    <= ST_RESP;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign s_adr_o  = fld.adr;
  assign s_dat_o  = fld.dat;
  assign s_sel_o  = fld.sel;
  assign s_we_o   = fld.we;
  assign s_cyc_o  = cyc_q;
  assign s_stb_o  = cyc_q;
  assign m0_dat_o = rdata;
  assign m1_dat_o = rdata;
  assign grant_o  = last_grant;

endmodule

// File: tb/tb_psram_wb_arbiter.sv
// Scoreboard bench for psram_wb_arbiter: master agents push expected responses,
// a negedge monitor pops and compares them against ack/err pulses.
module tb_psram_wb_arbiter;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] exp_dat;
  } txn_t;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  logic        m_cyc [2];
  logic        m_stb [2];
  logic        m_we  [2];
  logic        m_act [2];
  int          n_done [2];
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic        grant_o, busy_o;

  logic [31:0] t_adr, t_sdat, t_m0_dat, t_m1_dat, t_s_adr, t_s_dat;
  logic [3:0]  t_s_sel;
  logic        t_cyc, t_stb, t_ack;
  logic        t_m0_ack, t_m1_ack, t_m0_err, t_m1_err;
  logic        t_s_cyc, t_s_stb, t_s_we, t_grant, t_busy;

  logic [1:0]  ackv, errv;
  logic [31:0] datv [2];

  int   n_checks = 0;
  int   n_fail = 0;
  int   slv_lat = 3;
  int   stb_cnt = 0;
  bit   fld_chk = 0;
  int   rises = 0;
  int   low_run = 0;
  bit   prev_cyc = 0;
  int   gaps[$];
  int   served[$];
  txn_t pend0[$], pend1[$];
  exp_t exp0[$], exp1[$];

  assign ackv = {m1_ack_o, m0_ack_o};
  assign errv = {m1_err_o, m0_err_o};
  assign datv[0] = m0_dat_o;
  assign datv[1] = m1_dat_o;

  always #5 clk_i = ~clk_i;

  psram_wb_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]),
    .m0_dat_o(m0_dat_o), .m1_dat_o(m1_dat_o),
    .m0_ack_o(m0_ack_o), .m1_ack_o(m1_ack_o),
    .m0_err_o(m0_err_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  psram_wb_arbiter #(.TIMEOUT(8)) dut_t (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_adr_i(t_adr), .m0_dat_i(32'h0), .m0_sel_i(4'hF),
    .m0_cyc_i(t_cyc), .m0_stb_i(t_stb), .m0_we_i(1'b0),
    .m1_adr_i(32'h0), .m1_dat_i(32'h0), .m1_sel_i(4'h0),
    .m1_cyc_i(1'b0), .m1_stb_i(1'b0), .m1_we_i(1'b0),
    .m0_dat_o(t_m0_dat), .m1_dat_o(t_m1_dat),
    .m0_ack_o(t_m0_ack), .m1_ack_o(t_m1_ack),
    .m0_err_o(t_m0_err), .m1_err_o(t_m1_err),
    .s_adr_o(t_s_adr), .s_dat_o(t_s_dat), .s_sel_o(t_s_sel),
    .s_cyc_o(t_s_cyc), .s_stb_o(t_s_stb), .s_we_o(t_s_we),
    .s_dat_i(t_sdat), .s_ack_i(t_ack),
    .grant_o(t_grant), .busy_o(t_busy)
  );

  function automatic logic [31:0] slv_rdata(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int pend_size(input int i);
    return (i == 0) ? pend0.size() : pend1.size();
  endfunction

  function automatic txn_t pend_pop(input int i);
    txn_t t;
    if (i == 0) t = pend0.pop_front();
    else        t = pend1.pop_front();
    return t;
  endfunction

  function automatic void exp_push(input int i, input exp_t e);
    if (i == 0) exp0.push_back(e);
    else        exp1.push_back(e);
  endfunction

  // Master agent: issues queued transactions and drops cyc/stb after ack/err.
  task automatic agent(input int i);
    txn_t t;
    forever begin
      @(negedge clk_i);
      if (m_act[i] && (ackv[i] || errv[i])) begin
        @(posedge clk_i); #1;
        m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_act[i] = 1'b0;
        n_done[i]++;
      end else if (!m_act[i] && pend_size(i) != 0) begin
        t = pend_pop(i);
        @(posedge clk_i); #1;
        m_adr[i] = t.adr; m_dat[i] = t.dat; m_sel[i] = t.sel; m_we[i] = t.we;
        m_cyc[i] = 1'b1; m_stb[i] = 1'b1; m_act[i] = 1'b1;
        exp_push(i, '{t.exp_dat, 1'b0});
      end
    end
  endtask

  // Slave model: acks after slv_lat cycles of stb; slv_lat == 0 never acks.
  initial begin
    s_ack_i = 1'b0;
    s_dat_i = 32'h0;
    forever begin
      @(posedge clk_i); #1;
      s_ack_i = 1'b0;
      if (s_cyc_o && s_stb_o) stb_cnt++;
      else stb_cnt = 0;
      if (slv_lat != 0 && stb_cnt == slv_lat) begin
        s_ack_i = 1'b1;
        s_dat_i = slv_rdata(s_adr_o);
      end
    end
  end

  // Response monitor / scoreboard plus cyc gap and held-field tracking.
  always @(negedge clk_i) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (ackv[i] || errv[i]) begin
        served.push_back(i);
        if ((i == 0 && exp0.size() == 0) || (i == 1 && exp1.size() == 0)) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected response on m%0d: ack=%b err=%b, expected none", i, ackv[i], errv[i]);
        end else begin
          if (i == 0) e = exp0.pop_front();
          else        e = exp1.pop_front();
          check($sformatf("m%0d err flag", i), {31'b0, errv[i]}, {31'b0, e.err});
          if (!e.err) check($sformatf("m%0d read data", i), datv[i], e.dat);
        end
      end
    end
    if (fld_chk && busy_o && grant_o) begin
      check("m1 held adr", s_adr_o, 32'h0000_0200);
      check("m1 held dat", s_dat_o, 32'h1234_5678);
      check("m1 held sel", {28'b0, s_sel_o}, 32'h3);
      check("m1 held we", {31'b0, s_we_o}, 32'h1);
    end
    if (s_cyc_o && !prev_cyc) begin
      rises++;
      gaps.push_back(low_run);
    end
    if (s_cyc_o) low_run = 0;
    else low_run++;
    prev_cyc = s_cyc_o;
  end

  task automatic wait_done(input int i, input int target);
    int c = 0;
    while (n_done[i] < target && c < 500) begin
      @(negedge clk_i);
      c++;
    end
    check($sformatf("m%0d completions", i), n_done[i], target);
  endtask

  task automatic wait_busy(input string name);
    int c = 0;
    while (!busy_o && c < 100) begin
      @(negedge clk_i);
      c++;
    end
    check(name, {31'b0, busy_o}, 32'h1);
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL global time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int k;
    int r0;
    rst_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_adr[i] = '0; m_dat[i] = '0; m_sel[i] = '0;
      m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0; m_act[i] = 1'b0;
      n_done[i] = 0;
    end
    t_adr = '0; t_cyc = 1'b0; t_stb = 1'b0; t_ack = 1'b0; t_sdat = '0;
    fork
      agent(0);
      agent(1);
    join_none
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    @(negedge clk_i);
    check("reset s_cyc", {31'b0, s_cyc_o}, 32'h0);
    check("reset s_stb", {31'b0, s_stb_o}, 32'h0);
    check("reset s_adr", s_adr_o, 32'h0);
    check("reset s_we", {31'b0, s_we_o}, 32'h0);
    check("reset acks", {30'b0, ackv}, 32'h0);
    check("reset errs", {30'b0, errv}, 32'h0);
    check("reset dat_o", m0_dat_o, 32'h0);
    check("reset grant", {31'b0, grant_o}, 32'h1);
    check("reset busy", {31'b0, busy_o}, 32'h0);

    // single read, slow slave
    slv_lat = 10;
    pend0.push_back('{32'h0000_0100, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF});
    wait_done(0, 1);

    // simultaneous requests after reset: m0 first, m1 write held stable
    do_reset();
    served.delete();
    slv_lat = 3;
    fld_chk = 1;
    pend0.push_back('{32'h0000_0104, 32'h0, 4'hF, 1'b0, 32'h0104_FEFB});
    pend1.push_back('{32'h0000_0200, 32'h1234_5678, 4'b0011, 1'b1, 32'h0200_FDFF});
    wait_done(0, 2);
    wait_done(1, 1);
    fld_chk = 0;
    check("contention served count", served.size(), 2);
    if (served.size() == 2) begin
      check("contention first", served[0], 0);
      check("contention second", served[1], 1);
    end

    // six back-to-back transactions from both masters
    served.delete();
    gaps.delete();
    pend0.push_back('{32'h0000_0400, 32'h0, 4'hF, 1'b0, 32'h0400_FBFF});
    pend0.push_back('{32'h0000_0404, 32'h0, 4'hF, 1'b0, 32'h0404_FBFB});
    pend0.push_back('{32'h0000_0408, 32'h0, 4'hF, 1'b0, 32'h0408_FBF7});
    pend1.push_back('{32'h0000_0500, 32'h0, 4'hF, 1'b0, 32'h0500_FAFF});
    pend1.push_back('{32'h0000_0504, 32'h0, 4'hF, 1'b0, 32'h0504_FAFB});
    pend1.push_back('{32'h0000_0508, 32'h0, 4'hF, 1'b0, 32'h0508_FAF7});
    wait_done(0, 5);
    wait_done(1, 4);
    check("alternation served count", served.size(), 6);
    for (int i = 0; i < 6 && i < served.size(); i++)
      check($sformatf("alternation grant %0d", i), served[i], i % 2);
    check("alternation gap count", gaps.size(), 6);
    for (int i = 1; i < 6 && i < gaps.size(); i++)
      check($sformatf("cyc low gap %0d", i), gaps[i], 2);

    // reset three cycles into BUSY
    served.delete();
    slv_lat = 20;
    pend1.push_back('{32'h0000_0600, 32'h0, 4'hF, 1'b0, 32'h0600_F9FF});
    wait_busy("m1 reached busy");
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    pend0.push_back('{32'h0000_0700, 32'h0, 4'hF, 1'b0, 32'h0700_F8FF});
    #1;
    check("async reset s_cyc", {31'b0, s_cyc_o}, 32'h0);
    check("async reset s_stb", {31'b0, s_stb_o}, 32'h0);
    check("async reset busy", {31'b0, busy_o}, 32'h0);
    slv_lat = 4;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    wait_done(0, 6);
    wait_done(1, 5);
    check("post-reset served count", served.size(), 2);
    if (served.size() == 2) begin
      check("post-reset first", served[0], 0);
      check("post-reset second", served[1], 1);
    end

    // m1 drops cyc mid-transaction
    served.delete();
    repeat (2) @(negedge clk_i);
    r0 = rises;
    slv_lat = 6;
    pend1.push_back('{32'h0000_0800, 32'h0, 4'hF, 1'b0, 32'h0800_F7FF});
    wait_busy("m1 busy before cyc drop");
    repeat (2) @(posedge clk_i);
    #1 m_cyc[1] = 1'b0;
    wait_done(1, 6);
    repeat (4) @(negedge clk_i);
    check("cyc drop slave transactions", rises - r0, 1);
    check("cyc drop served count", served.size(), 1);

    // watchdog abort on the TIMEOUT=8 instance, then a normal transaction
    @(posedge clk_i); #1;
    t_adr = 32'h0000_0300; t_cyc = 1'b1; t_stb = 1'b1;
    k = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (k < 0) begin
        if (t_s_cyc) k = 0;
      end else begin
        k++;
      end
      if (t_m0_err) break;
    end
    check("timeout err latency", k, 9);
    check("timeout err pulse", {31'b0, t_m0_err}, 32'h1);
    check("timeout no ack", {31'b0, t_m0_ack}, 32'h0);
    check("timeout s_cyc dropped", {31'b0, t_s_cyc}, 32'h0);
    @(posedge clk_i); #1;
    t_cyc = 1'b0; t_stb = 1'b0;
    @(negedge clk_i);
    check("timeout err single pulse", {31'b0, t_m0_err}, 32'h0);
    @(posedge clk_i); #1;
    t_adr = 32'h0000_0304; t_cyc = 1'b1; t_stb = 1'b1;
    k = 0;
    while (!t_s_stb && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    check("post-timeout slave adr", t_s_adr, 32'h0000_0304);
    @(posedge clk_i); #1;
    t_ack = 1'b1; t_sdat = 32'hCAFE_0001;
    @(posedge clk_i); #1;
    t_ack = 1'b0;
    @(negedge clk_i);
    check("post-timeout ack", {31'b0, t_m0_ack}, 32'h1);
    check("post-timeout err", {31'b0, t_m0_err}, 32'h0);
    check("post-timeout data", t_m0_dat, 32'hCAFE_0001);
    @(posedge clk_i); #1;
    t_cyc = 1'b0; t_stb = 1'b0;

    repeat (3) @(negedge clk_i);
    check("m0 expectations left", exp0.size(), 0);
    check("m1 expectations left", exp1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
